// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done request and result bundle between the control unit and the divider
interface seq_divider_if #(parameter int DATA_BITS = 8);
  logic start;
  logic [DATA_BITS-1:0] dividend;
  logic [DATA_BITS-1:0] divisor;
  logic busy;
  logic done;
  logic [DATA_BITS-1:0] quotient;
  logic [DATA_BITS-1:0] remainder;
  logic div_by_zero;
  logic zero;
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider #(parameter int DATA_BITS = 8) (
  input logic clk,
  input logic reset_n,
  seq_divider_if.slave s
);
  localparam int CW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [DATA_BITS-1:0] dq, dsr, rem_acc, quo, rem, new_rem, q_n;
  logic [DATA_BITS:0] shifted, trial;
  logic [CW-1:0] cnt;
  logic last, dbz, zf, borrow;
  // dq holds the dividend bits still to consume and collects quotient bits from the right
  always_comb begin
    shifted = {rem_acc, dq[DATA_BITS-1]};
    trial = shifted - {1'b0, dsr};
    borrow = trial[DATA_BITS];
    new_rem = borrow ? shifted[DATA_BITS-1:0] : trial[DATA_BITS-1:0];
    q_n = {dq[DATA_BITS-2:0], ~borrow};
    last = cnt == CW'(DATA_BITS - 1);
    state_n = state == IDLE ? (s.start ? (s.divisor != '0 ? RUN : DONE) : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (!reset_n) begin
      {dq, dsr, rem_acc, quo, rem, cnt, dbz, zf} <= '0;
    end else if (state == IDLE && s.start) begin
      if (s.divisor != '0) begin
        dq <= s.dividend;
        dsr <= s.divisor;
        rem_acc <= '0;
        cnt <= '0;
      end else begin
        quo <= '1;
        rem <= s.dividend;
        dbz <= 1'b1;
        zf <= 1'b0;
      end
    end else if (state == RUN) begin
      dq <= q_n;
      rem_acc <= new_rem;
      cnt <= cnt + 1'b1;
      if (last) begin
        quo <= q_n;
        rem <= new_rem;
        dbz <= 1'b0;
        zf <= q_n == '0;
      end
    end
  assign s.busy = state != IDLE;
  assign s.done = state == DONE;
  assign s.quotient = quo;
  assign s.remainder = rem;
  assign s.div_by_zero = dbz;
  assign s.zero = zf;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divide operations checked against an arithmetic reference
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  logic [7:0] last_q = '0, last_r = '0;
  seq_divider_if #(.DATA_BITS(8)) io ();
  seq_divider #(.DATA_BITS(8)) dut (.clk(clk), .reset_n(reset_n), .s(io.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, io.busy, 0);
    chk({tag, "_done"}, io.done, 0);
    chk({tag, "_q"}, io.quotient, 0);
    chk({tag, "_r"}, io.remainder, 0);
    chk({tag, "_dbz"}, io.div_by_zero, 0);
    chk({tag, "_zero"}, io.zero, 0);
  endtask
  // Issue one op at the current negedge; pulse_at >= 0 injects a 9/2 start that must be dropped
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int pulse_at);
    logic [7:0] eq, er;
    logic ed, ez;
    int n, lat;
    eq = b == 0 ? 8'd255 : a / b;
    er = b == 0 ? a : a % b;
    ed = b == 0;
    ez = b != 0 && eq == 0;
    lat = b == 0 ? 0 : 8;
    io.start = 1'b1;
    io.dividend = a;
    io.divisor = b;
    @(negedge clk);
    n = 0;
    io.start = 1'b0;
    chk("busy_accept", io.busy, 1);
    while (!io.done && n < 40) begin
      chk("hold_q", io.quotient, last_q);
      chk("hold_r", io.remainder, last_r);
      io.dividend = 8'($urandom);
      io.divisor = 8'($urandom);
      io.start = n == pulse_at;
      if (n == pulse_at) begin
        io.dividend = 8'd9;
        io.divisor = 8'd2;
      end
      @(negedge clk);
      n++;
    end
    io.start = 1'b0;
    chk("latency", n, lat);
    chk("quotient", io.quotient, eq);
    chk("remainder", io.remainder, er);
    chk("div_by_zero", io.div_by_zero, ed);
    chk("zero", io.zero, ez);
    chk("busy_done", io.busy, 1);
    if (b != 0) begin
      chk("identity", io.quotient * b + io.remainder, a);
      chk("rem_lt_div", io.remainder < b, 1);
    end
    last_q = eq;
    last_r = er;
    @(negedge clk);
    chk("done_pulse", io.done, 0);
    chk("idle_after", io.busy, 0);
  endtask
  initial begin
    logic [7:0] a, b;
    reset_n = 1'b0;
    io.start = 1'b0;
    io.dividend = '0;
    io.divisor = '0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    reset_n = 1'b1;
    @(negedge clk);
    run_op(8'd200, 8'd7, -1);
    run_op(8'd3, 8'd10, -1);
    run_op(8'd5, 8'd0, -1);
    run_op(8'd255, 8'd1, -1);
    run_op(8'd255, 8'd255, -1);
    run_op(8'd100, 8'd3, 3);
    run_op(8'd0, 8'd9, -1);
    run_op(8'd200, 8'd7, -1);
    io.start = 1'b1;
    io.dividend = 8'd100;
    io.divisor = 8'd3;
    @(negedge clk);
    io.start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_cleared("midrun_reset");
    reset_n = 1'b1;
    last_q = '0;
    last_r = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", io.done, 0);
    end
    run_op(8'd50, 8'd7, -1);
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = i % 50 == 0 ? 8'd0 : 8'($urandom);
      run_op(a, b, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
